// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller.
// Holds the FSM encoding, the forwarding-select codes and a register-match helper.
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        FLUSH      = 2'd3
    } pipe_state_e;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A writer supplies src only if it really writes a register other than $0.
    function automatic logic reg_hit(input logic       we,
                                     input logic [4:0] rd,
                                     input logic [4:0] src);
        return we & (rd != REG_ZERO) & (rd == src);
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline-side signal bundle for the hazard controller.
// master = pipeline datapath, slave = hazard controller.
interface pipeline_hazard_controller_if;

    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       id_valid;
    logic       idex_memread;
    logic [4:0] idex_rt;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic       exmem_regwrite;
    logic [4:0] exmem_rd;
    logic       memwb_regwrite;
    logic [4:0] memwb_rd;
    logic       exmem_branch;
    logic       exmem_zero;
    logic       mem_busy;

    logic       pc_write;
    logic       ifid_write;
    logic       pipe_write;
    logic       idex_bubble;
    logic       pcsrc;
    logic       flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_valid, idex_memread, idex_rt,
               ex_rs, ex_rt, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd,
               exmem_branch, exmem_zero, mem_busy,
        input  pc_write, ifid_write, pipe_write, idex_bubble, pcsrc, flush,
               fwd_a, fwd_b
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_valid, idex_memread, idex_rt,
               ex_rs, ex_rt, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd,
               exmem_branch, exmem_zero, mem_busy,
        output pc_write, ifid_write, pipe_write, idex_bubble, pcsrc, flush,
               fwd_a, fwd_b
    );

endinterface

// File: rtl/pipeline_hazard_controller_fwd.sv
// ALU operand forwarding selects for the EX stage.
// EX/MEM has priority over MEM/WB; $0 is never forwarded.
module forwarding_unit
    import mips_pipe_pkg::*;
(
    input  logic       exmem_regwrite,
    input  logic [4:0] exmem_rd,
    input  logic       memwb_regwrite,
    input  logic [4:0] memwb_rd,
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    always_comb begin
        fwd_a = FWD_REG;
        if (reg_hit(exmem_regwrite, exmem_rd, ex_rs)) begin
            fwd_a = FWD_EXMEM;
        end else if (reg_hit(memwb_regwrite, memwb_rd, ex_rs)) begin
            fwd_a = FWD_MEMWB;
        end
    end

    always_comb begin
        fwd_b = FWD_REG;
        if (reg_hit(exmem_regwrite, exmem_rd, ex_rt)) begin
            fwd_b = FWD_EXMEM;
        end else if (reg_hit(memwb_regwrite, memwb_rd, ex_rt)) begin
            fwd_b = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: load-use stalls,
// taken-branch flushes, memory-wait freeze with timeout, and operand forwarding.
module pipeline_hazard_controller
    import mips_pipe_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned WAIT_TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    pipeline_hazard_controller_if.slave   hz,
    output logic [1:0]                    state,
    output logic [CNT_W-1:0]              stall_cnt,
    output logic [CNT_W-1:0]              flush_cnt,
    output logic                          timeout_err
);

    localparam int unsigned     WAIT_W   = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_TIMEOUT);

    pipe_state_e       state_q, state_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_err_q, timeout_err_d;

    logic       taken;
    logic       lu;
    logic       pc_write_c;
    logic       ifid_write_c;
    logic       pipe_write_c;
    logic       idex_bubble_c;
    logic       pcsrc_c;
    logic       flush_c;
    logic [1:0] fwd_a_c;
    logic [1:0] fwd_b_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    forwarding_unit u_fwd (
        .exmem_regwrite (hz.exmem_regwrite),
        .exmem_rd       (hz.exmem_rd),
        .memwb_regwrite (hz.memwb_regwrite),
        .memwb_rd       (hz.memwb_rd),
        .ex_rs          (hz.ex_rs),
        .ex_rt          (hz.ex_rt),
        .fwd_a          (fwd_a_c),
        .fwd_b          (fwd_b_c)
    );

    // The instruction in IF/ID is a flushed slot while in FLUSH, so lu is masked there.
    always_comb begin
        taken = hz.exmem_branch & hz.exmem_zero;
        lu    = hz.id_valid & hz.idex_memread & (hz.idex_rt != REG_ZERO) &
                ((hz.idex_rt == hz.id_rs) | (hz.id_uses_rt & (hz.idex_rt == hz.id_rt))) &
                (state_q != FLUSH);
    end

    always_comb begin
        state_d       = RUN;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        wait_cnt_d    = '0;
        timeout_err_d = timeout_err_q;
        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        pipe_write_c  = 1'b1;
        idex_bubble_c = 1'b0;
        pcsrc_c       = 1'b0;
        flush_c       = 1'b0;

        if (hz.mem_busy) begin
            // Full freeze; a pending taken branch stays in EX/MEM until memory frees.
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            pipe_write_c = 1'b0;
            state_d      = MEM_WAIT;
            stall_cnt_d  = sat_inc(stall_cnt_q);
            wait_cnt_d   = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
            if (wait_cnt_d == WAIT_MAX) begin
                timeout_err_d = 1'b1;
            end
        end else if (taken) begin
            pcsrc_c     = 1'b1;
            flush_c     = 1'b1;
            state_d     = FLUSH;
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else if (lu) begin
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            idex_bubble_c = 1'b1;
            state_d       = LOAD_STALL;
            stall_cnt_d   = sat_inc(stall_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Combinational controls are held inactive for the whole time reset is low.
    always_comb begin
        hz.pc_write    = reset & pc_write_c;
        hz.ifid_write  = reset & ifid_write_c;
        hz.pipe_write  = reset & pipe_write_c;
        hz.idex_bubble = reset & idex_bubble_c;
        hz.pcsrc       = reset & pcsrc_c;
        hz.flush       = reset & flush_c;
        hz.fwd_a       = reset ? fwd_a_c : FWD_REG;
        hz.fwd_b       = reset ? fwd_b_c : FWD_REG;
    end

    assign state       = state_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios plus
// randomized traffic compared every cycle against a behavioural model.
module tb_pipeline_hazard_controller;

    localparam int CW   = 4;
    localparam int WT   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    state;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
    logic          timeout_err;

    pipeline_hazard_controller_if hz();

    pipeline_hazard_controller #(.CNT_W(CW), .WAIT_TIMEOUT(WT)) dut (
        .clk         (clk),
        .reset       (reset),
        .hz          (hz),
        .state       (state),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: mode number, event counters, consecutive busy cycles, sticky error.
    int m_state, m_stall, m_flush, m_busy_run;
    bit m_err;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_stall = 0; m_flush = 0; m_busy_run = 0; m_err = 0;
    endtask

    function automatic bit load_use();
        if (m_state == 3) return 0;
        return hz.id_valid && hz.idex_memread && hz.idex_rt != 0 &&
               (hz.idex_rt == hz.id_rs || (hz.id_uses_rt && hz.idex_rt == hz.id_rt));
    endfunction

    function automatic int fwd_of(input logic [4:0] src);
        if (hz.exmem_regwrite && hz.exmem_rd != 0 && hz.exmem_rd == src) return 2;
        if (hz.memwb_regwrite && hz.memwb_rd != 0 && hz.memwb_rd == src) return 1;
        return 0;
    endfunction

    task automatic check_now();
        bit freeze, redirect, hold;
        int e_fa, e_fb;
        freeze   = hz.mem_busy;
        redirect = !freeze && hz.exmem_branch && hz.exmem_zero;
        hold     = !freeze && !redirect && load_use();
        e_fa = fwd_of(hz.ex_rs);
        e_fb = fwd_of(hz.ex_rt);
        if (!reset) begin
            freeze = 1; redirect = 0; hold = 0; e_fa = 0; e_fb = 0;
        end
        chk("pc_write",    hz.pc_write,    (reset && !freeze && !hold) ? 1 : 0);
        chk("ifid_write",  hz.ifid_write,  (reset && !freeze && !hold) ? 1 : 0);
        chk("pipe_write",  hz.pipe_write,  (reset && !freeze) ? 1 : 0);
        chk("idex_bubble", hz.idex_bubble, hold ? 1 : 0);
        chk("pcsrc",       hz.pcsrc,       redirect ? 1 : 0);
        chk("flush",       hz.flush,       redirect ? 1 : 0);
        chk("fwd_a",       hz.fwd_a,       e_fa);
        chk("fwd_b",       hz.fwd_b,       e_fb);
        chk("state",       state,          m_state);
        chk("stall_cnt",   stall_cnt,      m_stall);
        chk("flush_cnt",   flush_cnt,      m_flush);
        chk("timeout_err", timeout_err,    m_err ? 1 : 0);
    endtask

    task automatic model_step();
        if (!reset) return;
        if (hz.mem_busy) begin
            m_state = 2;
            if (m_stall < CMAX) m_stall++;
            m_busy_run++;
            if (m_busy_run >= WT) m_err = 1;
        end else begin
            m_busy_run = 0;
            if (hz.exmem_branch && hz.exmem_zero) begin
                m_state = 3;
                if (m_flush < CMAX) m_flush++;
            end else if (load_use()) begin
                m_state = 1;
                if (m_stall < CMAX) m_stall++;
            end else begin
                m_state = 0;
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        check_now();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        hz.id_rs = 0; hz.id_rt = 0; hz.id_uses_rt = 0; hz.id_valid = 0;
        hz.idex_memread = 0; hz.idex_rt = 0; hz.ex_rs = 0; hz.ex_rt = 0;
        hz.exmem_regwrite = 0; hz.exmem_rd = 0; hz.memwb_regwrite = 0; hz.memwb_rd = 0;
        hz.exmem_branch = 0; hz.exmem_zero = 0; hz.mem_busy = 0;
    endtask

    task automatic set_lu();
        hz.id_valid = 1; hz.id_rs = 8; hz.idex_memread = 1; hz.idex_rt = 8;
    endtask

    task automatic async_reset_pulse();
        #2;
        reset = 0;
        model_reset();
        #1;
        check_now();
        tick();
        reset = 1;
    endtask

    task automatic randomize_inputs();
        hz.id_rs          = 5'($urandom_range(0, 3));
        hz.id_rt          = 5'($urandom_range(0, 3));
        hz.id_uses_rt     = 1'($urandom_range(0, 1));
        hz.id_valid       = 1'($urandom_range(0, 3) != 0);
        hz.idex_memread   = 1'($urandom_range(0, 1));
        hz.idex_rt        = 5'($urandom_range(0, 3));
        hz.ex_rs          = 5'($urandom_range(0, 3));
        hz.ex_rt          = 5'($urandom_range(0, 3));
        hz.exmem_regwrite = 1'($urandom_range(0, 1));
        hz.exmem_rd       = 5'($urandom_range(0, 3));
        hz.memwb_regwrite = 1'($urandom_range(0, 1));
        hz.memwb_rd       = 5'($urandom_range(0, 3));
        hz.exmem_branch   = 1'($urandom_range(0, 3) == 0);
        hz.exmem_zero     = 1'($urandom_range(0, 1));
        hz.mem_busy       = 1'($urandom_range(0, 5) == 0);
    endtask

    initial begin
        idle();
        model_reset();
        reset = 0;
        #3;
        check_now();
        chk("lit_reset_state", state, 0);
        @(posedge clk);
        #1;
        reset = 1;

        // Load-use on rs, then the bubble releases the stall.
        set_lu();
        sample();
        chk("lit_lu_pc_write", hz.pc_write, 0);
        chk("lit_lu_ifid_write", hz.ifid_write, 0);
        chk("lit_lu_bubble", hz.idex_bubble, 1);
        tick();
        hz.idex_memread = 0;
        sample();
        chk("lit_lu_state", state, 1);
        chk("lit_lu_stall_cnt", stall_cnt, 1);
        chk("lit_lu_release", hz.pc_write, 1);
        tick();
        hz.idex_memread = 1; hz.idex_rt = 0; hz.id_rs = 0;
        sample();
        chk("lit_lu_r0_bubble", hz.idex_bubble, 0);
        tick();

        // Forwarding priority and $0 exclusion.
        idle();
        hz.exmem_regwrite = 1; hz.exmem_rd = 5; hz.memwb_regwrite = 1; hz.memwb_rd = 5;
        hz.ex_rs = 5; hz.ex_rt = 9;
        sample();
        chk("lit_fwd_a_exmem", hz.fwd_a, 2);
        chk("lit_fwd_b_none", hz.fwd_b, 0);
        tick();
        hz.exmem_rd = 0;
        sample();
        chk("lit_fwd_a_memwb", hz.fwd_a, 1);
        tick();

        // Taken branch beats a simultaneous load-use; lu stays masked in FLUSH.
        idle();
        set_lu();
        hz.exmem_branch = 1; hz.exmem_zero = 1;
        sample();
        chk("lit_br_pcsrc", hz.pcsrc, 1);
        chk("lit_br_flush", hz.flush, 1);
        chk("lit_br_pc_write", hz.pc_write, 1);
        chk("lit_br_bubble", hz.idex_bubble, 0);
        tick();
        hz.exmem_branch = 0;
        sample();
        chk("lit_br_state", state, 3);
        chk("lit_br_flush_cnt", flush_cnt, 1);
        chk("lit_flush_lu_masked", hz.idex_bubble, 0);
        tick();
        idle();
        sample();
        chk("lit_br_back_run", state, 0);
        tick();

        // Build stall_cnt to 7, then assert reset asynchronously.
        set_lu();
        repeat (6) begin sample(); tick(); end
        idle();
        hz.exmem_regwrite = 1; hz.exmem_rd = 3; hz.ex_rs = 3;
        sample();
        chk("lit_pre_reset_stall", stall_cnt, 7);
        chk("lit_pre_reset_fwd_a", hz.fwd_a, 2);
        async_reset_pulse();
        chk("lit_async_stall_cnt", stall_cnt, 0);
        chk("lit_async_fwd_a", hz.fwd_a, 0);

        // Branch held under three memory-wait cycles.
        idle();
        hz.exmem_branch = 1; hz.exmem_zero = 1; hz.mem_busy = 1;
        repeat (3) begin
            sample();
            chk("lit_busy_pcsrc", hz.pcsrc, 0);
            tick();
        end
        hz.mem_busy = 0;
        sample();
        chk("lit_busy_stall_cnt", stall_cnt, 3);
        chk("lit_busy_state", state, 2);
        chk("lit_busy_then_pcsrc", hz.pcsrc, 1);
        chk("lit_busy_then_flush", hz.flush, 1);
        tick();
        hz.exmem_branch = 0;
        sample();
        chk("lit_busy_flush_cnt", flush_cnt, 1);
        tick();

        // Non-consecutive waits do not accumulate; a long wait sets sticky timeout.
        idle();
        hz.mem_busy = 1;
        repeat (WT - 1) begin sample(); tick(); end
        hz.mem_busy = 0;
        sample(); tick();
        hz.mem_busy = 1;
        repeat (WT - 1) begin sample(); tick(); end
        hz.mem_busy = 0;
        sample();
        chk("lit_no_timeout", timeout_err, 0);
        tick();
        hz.mem_busy = 1;
        repeat (WT + 1) begin sample(); tick(); end
        hz.mem_busy = 0;
        sample();
        chk("lit_timeout_set", timeout_err, 1);
        tick();
        repeat (3) begin sample(); tick(); end
        sample();
        chk("lit_timeout_sticky", timeout_err, 1);
        async_reset_pulse();
        chk("lit_timeout_cleared", timeout_err, 0);

        // Counter saturation.
        idle();
        set_lu();
        repeat (CMAX + 5) begin sample(); tick(); end
        idle();
        sample();
        chk("lit_stall_saturated", stall_cnt, CMAX);
        tick();

        // Randomized traffic with occasional asynchronous resets.
        for (int blk = 0; blk < 6; blk++) begin
            for (int c = 0; c < 500; c++) begin
                randomize_inputs();
                sample();
                tick();
            end
            async_reset_pulse();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
